// File: rtl/sr_delay_bank_pkg.sv
// Shared constants and helpers for the sr_delay_bank multi-channel delay line.
// Channel i occupies bits [lane_lo(i, WIDTH) +: WIDTH] of the packed d/q buses.
package sr_delay_bank_pkg;

  localparam int DEF_CHANNELS = 24;
  localparam int DEF_WIDTH    = 1;
  localparam int DEF_DEPTH    = 16;
  localparam int DEF_ABITS    = 4;
  localparam int DEF_CBITS    = $clog2(DEF_CHANNELS);
  // Register delay for behavioural models; the synthesizable RTL applies none.
  localparam int DEF_DELAY    = 3;

  function automatic int lane_lo(input int idx, input int width);
    return idx * width;
  endfunction

endpackage

// File: rtl/sr_delay_chan.sv
// One delay channel: SRL-style shifter with runtime tap, saturating settle
// counter and registered settled flag.
module sr_delay_chan
  import sr_delay_bank_pkg::*;
#(
  parameter int               WIDTH = DEF_WIDTH,
  parameter int               DEPTH = DEF_DEPTH,
  parameter int               ABITS = DEF_ABITS,
  parameter logic [WIDTH-1:0] INIT  = '0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             ce,
  input  logic [WIDTH-1:0] d,
  input  logic             wr,
  input  logic [ABITS-1:0] wr_dly,
  output logic [WIDTH-1:0] q,
  output logic             q_vld,
  output logic [ABITS-1:0] tap
);

  localparam logic [ABITS:0] CNT_MAX = (ABITS + 1)'(DEPTH);

  logic [DEPTH-1:0][WIDTH-1:0] mem;
  logic [ABITS:0]              cnt;
  logic [ABITS:0]              cnt_next;
  logic [ABITS-1:0]            tap_next;
  logic                        wr_eff;

  // Rewriting the current tap must leave the settle state alone.
  assign wr_eff = wr && (wr_dly != tap);

  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    tap_next = tap;
    cnt_next = cnt;
    if (wr_eff) begin
      tap_next = wr_dly;
      cnt_next = '0;
    end else if (ce && (cnt != CNT_MAX)) begin
      cnt_next = cnt + (ABITS + 1)'(1);
    end
  end

  // NOTE: the storage is reset on purpose so q is defined (INIT) during reset;
  // this gives up true SRL mapping in exchange for deterministic alignment.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem   <= {DEPTH{INIT}};
      tap   <= '0;
      cnt   <= '0;
      q_vld <= 1'b0;
    end else begin
      if (ce) mem <= {mem[DEPTH-2:0], d};
      tap   <= tap_next;
      cnt   <= cnt_next;
      q_vld <= cnt_next > {1'b0, tap_next};
    end
  end

  assign q = mem[tap];

endmodule

// File: rtl/sr_delay_bank.sv
// Bank of independent programmable delay channels for per-antenna skew
// compensation, with a channel-addressed tap write port and tap readback.
module sr_delay_bank
  import sr_delay_bank_pkg::*;
#(
  parameter int               CHANNELS = DEF_CHANNELS,
  parameter int               WIDTH    = DEF_WIDTH,
  parameter int               DEPTH    = DEF_DEPTH,
  parameter int               ABITS    = DEF_ABITS,
  parameter int               CBITS    = $clog2(CHANNELS),
  parameter logic [WIDTH-1:0] INIT     = '0
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      ce,
  input  logic [CHANNELS*WIDTH-1:0] d,
  output logic [CHANNELS*WIDTH-1:0] q,
  output logic [CHANNELS-1:0]       q_vld,
  output logic                      all_vld,
  input  logic                      set_en,
  input  logic [CBITS-1:0]          set_chan,
  input  logic [ABITS-1:0]          set_dly,
  input  logic [CBITS-1:0]          rd_chan,
  output logic [ABITS-1:0]          rd_dly
);

  logic [ABITS-1:0] taps [CHANNELS];

  for (genvar i = 0; i < CHANNELS; i++) begin : g_chan
    logic wr;
    // Out-of-range set_chan values match no channel and are dropped.
    assign wr = set_en && (set_chan == CBITS'(i));

    sr_delay_chan #(
      .WIDTH (WIDTH),
      .DEPTH (DEPTH),
      .ABITS (ABITS),
      .INIT  (INIT)
    ) u_chan (
      .clk    (clk),
      .rst_n  (rst_n),
      .ce     (ce),
      .d      (d[lane_lo(i, WIDTH) +: WIDTH]),
      .wr     (wr),
      .wr_dly (set_dly),
      .q      (q[lane_lo(i, WIDTH) +: WIDTH]),
      .q_vld  (q_vld[i]),
      .tap    (taps[i])
    );
  end

  assign all_vld = &q_vld;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_dly <= '0;
    end else if (int'(rd_chan) < CHANNELS) begin
      rd_dly <= taps[rd_chan];
    end else begin
      rd_dly <= '0;
    end
  end

endmodule

// File: tb/tb_sr_delay_bank.sv
// Directed self-checking bench for sr_delay_bank (24 x 1-bit, depth 16).
module tb_sr_delay_bank;

  localparam int CH    = 24;
  localparam int ABITS = 4;
  localparam int CBITS = 5;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             ce;
  logic [CH-1:0]    d;
  logic [CH-1:0]    q;
  logic [CH-1:0]    q_vld;
  logic             all_vld;
  logic             set_en;
  logic [CBITS-1:0] set_chan;
  logic [ABITS-1:0] set_dly;
  logic [CBITS-1:0] rd_chan;
  logic [ABITS-1:0] rd_dly;

  int tests_run    = 0;
  int tests_failed = 0;

  sr_delay_bank dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .ce       (ce),
    .d        (d),
    .q        (q),
    .q_vld    (q_vld),
    .all_vld  (all_vld),
    .set_en   (set_en),
    .set_chan (set_chan),
    .set_dly  (set_dly),
    .rd_chan  (rd_chan),
    .rd_dly   (rd_dly)
  );

  always #5 clk = ~clk;

  // Advance one rising edge, then settle 1 time unit before sampling/driving.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    tests_run++;
    if (q !== '0) begin
      tests_failed++; $display("FAIL reset_q got %h want %h", q, 24'h0);
    end
    tests_run++;
    if (q_vld !== '0 || all_vld !== 1'b0) begin
      tests_failed++; $display("FAIL reset_vld got %h/%b want 0/0", q_vld, all_vld);
    end
    tests_run++;
    if (rd_dly !== '0) begin
      tests_failed++; $display("FAIL reset_rd_dly got %0d want 0", rd_dly);
    end
  endtask

  task automatic test_follow();
    logic [CH-1:0] pat [3];
    logic [CH-1:0] prev;
    pat[0] = '1; pat[1] = '0; pat[2] = 24'hA5A5A5;
    ce = 1'b1;
    prev = '0;
    for (int k = 0; k < 3; k++) begin
      d = pat[k];
      #1;
      tests_run++;
      if (q !== prev) begin
        tests_failed++; $display("FAIL follow_pre%0d got %h want %h", k, q, prev);
      end
      tick();
      tests_run++;
      if (q !== pat[k]) begin
        tests_failed++; $display("FAIL follow%0d got %h want %h", k, q, pat[k]);
      end
      tests_run++;
      if (q_vld !== '1 || all_vld !== 1'b1) begin
        tests_failed++; $display("FAIL follow_vld%0d got %h/%b want ffffff/1", k, q_vld, all_vld);
      end
      prev = pat[k];
    end
    d = '0;
    for (int k = 0; k < 16; k++) tick();
  endtask

  task automatic test_tap5();
    logic exp_q, exp_v;
    set_en = 1'b1; set_chan = 5'd3; set_dly = 4'd5; d = '0;
    tick();
    set_en = 1'b0;
    tests_run++;
    if (q_vld[3] !== 1'b0 || q_vld[2] !== 1'b1) begin
      tests_failed++; $display("FAIL tap5_write_vld got %h want q_vld[3]=0 others 1", q_vld);
    end
    d[3] = 1'b1;
    for (int n = 1; n <= 8; n++) begin
      tick();
      d = '0;
      exp_q = (n == 6);
      exp_v = (n >= 6);
      tests_run++;
      if (q[3] !== exp_q) begin
        tests_failed++; $display("FAIL tap5_q edge%0d got %b want %b", n, q[3], exp_q);
      end
      tests_run++;
      if (q_vld[3] !== exp_v) begin
        tests_failed++; $display("FAIL tap5_vld edge%0d got %b want %b", n, q_vld[3], exp_v);
      end
      tests_run++;
      if ((q & ~24'h000008) !== '0 || (q_vld | 24'h000008) !== '1) begin
        tests_failed++; $display("FAIL tap5_others edge%0d q %h vld %h", n, q, q_vld);
      end
    end
    rd_chan = 5'd3;
    tick();
    tests_run++;
    if (rd_dly !== 4'd5) begin
      tests_failed++; $display("FAIL tap5_rd got %0d want 5", rd_dly);
    end
  endtask

  task automatic test_ce_gating();
    logic ce_seq [8];
    logic q_exp  [8];
    logic v_exp  [8];
    ce_seq = '{1, 0, 0, 1, 0, 1, 0, 1};
    q_exp  = '{0, 0, 0, 0, 0, 1, 1, 0};
    v_exp  = '{0, 0, 0, 0, 0, 1, 1, 1};
    ce = 1'b0;
    set_en = 1'b1; set_chan = 5'd5; set_dly = 4'd2;
    tick();
    set_en = 1'b0;
    tests_run++;
    if (q_vld[5] !== 1'b0) begin
      tests_failed++; $display("FAIL gate_write_vld got %b want 0", q_vld[5]);
    end
    for (int s = 0; s < 8; s++) begin
      ce = ce_seq[s];
      d[5] = (s == 0);
      tick();
      tests_run++;
      if (q[5] !== q_exp[s] || q_vld[5] !== v_exp[s]) begin
        tests_failed++;
        $display("FAIL gate step%0d got q=%b vld=%b want q=%b vld=%b", s, q[5], q_vld[5], q_exp[s], v_exp[s]);
      end
    end
    d = '0;
    ce = 1'b1;
  endtask

  task automatic test_ignored_write();
    logic [ABITS-1:0] exp;
    set_en = 1'b1; set_chan = 5'd30; set_dly = 4'd9;
    tick();
    set_chan = 5'd3; set_dly = 4'd5;
    tick();
    set_en = 1'b0;
    tests_run++;
    if (q_vld !== '1) begin
      tests_failed++; $display("FAIL ignored_vld got %h want ffffff", q_vld);
    end
    for (int c = 0; c < 32; c += 1) begin
      if (c >= CH && c != 30) continue;
      rd_chan = CBITS'(c);
      tick();
      exp = (c == 3) ? 4'd5 : (c == 5) ? 4'd2 : 4'd0;
      tests_run++;
      if (rd_dly !== exp) begin
        tests_failed++; $display("FAIL ignored_rd ch%0d got %0d want %0d", c, rd_dly, exp);
      end
    end
  endtask

  task automatic test_write_with_ce();
    logic exp_v;
    ce = 1'b1; rd_chan = 5'd7;
    set_en = 1'b1; set_chan = 5'd7; set_dly = 4'd15;
    tick();
    set_en = 1'b0;
    tests_run++;
    if (q_vld[7] !== 1'b0 || rd_dly !== 4'd0) begin
      tests_failed++; $display("FAIL wce_edge got vld=%b rd=%0d want 0/0", q_vld[7], rd_dly);
    end
    for (int n = 1; n <= 17; n++) begin
      tick();
      exp_v = (n >= 16);
      tests_run++;
      if (q_vld[7] !== exp_v || all_vld !== exp_v) begin
        tests_failed++; $display("FAIL wce_vld edge%0d got %b/%b want %b", n, q_vld[7], all_vld, exp_v);
      end
      if (n == 1) begin
        tests_run++;
        if (rd_dly !== 4'd15) begin
          tests_failed++; $display("FAIL wce_rd got %0d want 15", rd_dly);
        end
      end
    end
    // Counters must saturate, not wrap, over a long ce run.
    for (int n = 0; n < 40; n++) tick();
    tests_run++;
    if (q_vld !== '1) begin
      tests_failed++; $display("FAIL saturate_vld got %h want ffffff", q_vld);
    end
  endtask

  task automatic test_reset_mid();
    d = '1; ce = 1'b1;
    tick(); tick();
    tests_run++;
    if (q[0] !== 1'b1) begin
      tests_failed++; $display("FAIL mid_pre_q got %b want 1", q[0]);
    end
    #2;
    rst_n = 1'b0;
    #1;
    tests_run++;
    if (q !== '0 || q_vld !== '0 || all_vld !== 1'b0) begin
      tests_failed++; $display("FAIL mid_async got q=%h vld=%h all=%b want 0/0/0", q, q_vld, all_vld);
    end
    d = '0; ce = 1'b0;
    tick();
    rst_n = 1'b1;
    for (int c = 0; c < CH; c++) begin
      rd_chan = CBITS'(c);
      tick();
      tests_run++;
      if (rd_dly !== '0) begin
        tests_failed++; $display("FAIL mid_rd ch%0d got %0d want 0", c, rd_dly);
      end
    end
    ce = 1'b1;
    tick();
    tests_run++;
    if (q_vld !== '1 || all_vld !== 1'b1) begin
      tests_failed++; $display("FAIL mid_resettle got %h/%b want ffffff/1", q_vld, all_vld);
    end
  endtask

  initial begin
    rst_n = 1'b0; ce = 1'b0; d = '0;
    set_en = 1'b0; set_chan = '0; set_dly = '0; rd_chan = '0;
    repeat (3) tick();
    test_reset();
    rst_n = 1'b1;
    test_follow();
    test_tap5();
    test_ce_gating();
    test_ignored_write();
    test_write_with_ce();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

endmodule
